// File: rtl/peripheral_bcdconv.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_bcdconv
// Brief    : Bus-mapped binary<->packed-BCD converter, one bit per clock
//            (double dabble / reverse double dabble) with status and irq.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_bcdconv #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] d_in,
    input  logic        cs,
    input  logic [4:0]  addr,
    input  logic        rd,
    input  logic        wr,
    output logic [31:0] d_out,
    output logic        irq
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_SR_W  = c_BCD_W + WIDTH;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(1);

    localparam logic [4:0] c_ADDR_DATA   = 5'h04;
    localparam logic [4:0] c_ADDR_MODE   = 5'h08;
    localparam logic [4:0] c_ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] c_ADDR_STATUS = 5'h10;
    localparam logic [4:0] c_ADDR_RESULT = 5'h14;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_SHIFT  = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t              r_state;
    logic [31:0]         r_data_in;
    logic [1:0]          r_mode;
    logic [31:0]         r_snap;
    logic                r_dir;
    logic [c_SR_W-1:0]   r_sr;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [31:0]         r_result;
    logic                r_done;
    logic                r_err;
    logic [31:0]         r_dout;

    logic                w_start;
    logic                w_busy;
    logic                w_bad;
    logic [c_SR_W-1:0]   w_fwd;
    logic [c_SR_W-1:0]   w_rev;
    logic                w_unused_ok;

    assign w_start     = cs && wr && (addr == c_ADDR_CTRL) && d_in[0];
    assign w_busy      = (r_state != S_IDLE);
    assign w_unused_ok = &{1'b0, r_snap};

    // Per-digit corrections: forward adjusts before the shift, reverse after.
    always_comb begin
        w_fwd = r_sr;
        w_rev = {1'b0, r_sr[c_SR_W-1:1]};
        w_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_sr[WIDTH+4*d +: 4] >= 4'd5)
                w_fwd[WIDTH+4*d +: 4] = r_sr[WIDTH+4*d +: 4] + 4'd3;
            if (w_rev[WIDTH+4*d +: 4] >= 4'd8)
                w_rev[WIDTH+4*d +: 4] = w_rev[WIDTH+4*d +: 4] - 4'd3;
            if (r_snap[4*d +: 4] > 4'd9)
                w_bad = 1'b1;
        end
        w_fwd = {w_fwd[c_SR_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_data_in <= '0;
            r_mode    <= '0;
            r_snap    <= '0;
            r_dir     <= 1'b0;
            r_sr      <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (cs && wr) begin
                case (addr)
                    c_ADDR_DATA: r_data_in <= d_in;
                    c_ADDR_MODE: r_mode    <= d_in[1:0];
                    default:     ;
                endcase
            end

            if (cs && rd) begin
                case (addr)
                    c_ADDR_STATUS: r_dout <= {29'd0, r_err, w_busy, r_done};
                    c_ADDR_RESULT: r_dout <= r_result;
                    default:       r_dout <= '0;
                endcase
            end else begin
                r_dout <= '0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_snap  <= r_data_in;
                        r_dir   <= r_mode[0];
                        r_done  <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt <= c_CNT_INIT;
                    if (!r_dir) begin
                        r_sr    <= {{c_BCD_W{1'b0}}, r_snap[WIDTH-1:0]};
                        r_state <= S_SHIFT;
                    end else begin
                        r_sr <= {r_snap[c_BCD_W-1:0], {WIDTH{1'b0}}};
                        if (w_bad) begin
                            r_err   <= 1'b1;
                            r_state <= S_FINISH;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sr  <= r_dir ? w_rev : w_fwd;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == c_CNT_LAST)
                        r_state <= S_FINISH;
                end
                S_FINISH: begin
                    if (!r_dir) begin
                        r_result <= 32'(r_sr[c_SR_W-1:WIDTH]);
                    end else if (r_err || (r_sr[c_SR_W-1:WIDTH] != '0)) begin
                        // Leftover BCD weight means the value exceeds WIDTH bits.
                        r_err    <= 1'b1;
                        r_result <= '0;
                    end else begin
                        r_result <= 32'(r_sr[WIDTH-1:0]);
                    end
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign d_out = r_dout;
    assign irq   = r_done & r_mode[1];

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bcdconv.sv
`default_nettype none
// ============================================================================
// Module   : tb_peripheral_bcdconv
// Brief    : Directed plus random checks of peripheral_bcdconv against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_peripheral_bcdconv;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    localparam logic [4:0] A_DATA   = 5'h04;
    localparam logic [4:0] A_MODE   = 5'h08;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;
    localparam logic [4:0] A_RESULT = 5'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] d_in = '0;
    logic        cs = 1'b0;
    logic [4:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] d_out;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    peripheral_bcdconv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; addr = a;
        @(negedge clk);
        d = d_out;
        cs = 1'b0; rd = 1'b0;
    endtask

    // Polls STATUS every cycle; returns edges from start until done was set.
    task automatic wait_done(output int lat, output logic [31:0] status);
        int cyc = 0;
        logic hit = 1'b0;
        cs = 1'b1; rd = 1'b1; addr = A_STATUS;
        status = '0;
        while (!hit && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_out[0]) begin
                hit = 1'b1;
                status = d_out;
            end
        end
        cs = 1'b0; rd = 1'b0;
        lat = cyc - 1;
        check("done_timeout", {31'd0, !hit}, 32'd0);
    endtask

    function automatic logic [31:0] model_to_bcd(input int unsigned v);
        logic [31:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    // Returns {err, result} as the peripheral should present them.
    function automatic logic [32:0] model_from_bcd(input logic [31:0] b);
        int unsigned v = 0;
        int unsigned w = 1;
        logic bad = 1'b0;
        logic [3:0] nib;
        for (int i = 0; i < DIGITS; i++) begin
            nib = b[4*i +: 4];
            if (nib > 4'd9) bad = 1'b1;
            v = v + nib * w;
            w = w * 10;
        end
        if (bad || v > (2**WIDTH - 1)) return {1'b1, 32'd0};
        return {1'b0, v};
    endfunction

    task automatic convert(input logic [1:0] mode, input logic [31:0] data,
                           output int lat, output logic [31:0] status,
                           output logic [31:0] result);
        bus_write(A_MODE, {30'd0, mode});
        bus_write(A_DATA, data);
        bus_write(A_CTRL, 32'd1);
        wait_done(lat, status);
        bus_read(A_RESULT, result);
    endtask

    initial begin
        int lat;
        logic [31:0] st, res, rv, b;
        logic [32:0] m;
        int unsigned v;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_dout", d_out, 32'd0);
        bus_read(A_STATUS, rv);
        check("rst_status", rv, 32'd0);
        bus_read(A_RESULT, rv);
        check("rst_result", rv, 32'd0);

        // bin->bcd directed
        convert(2'b00, 32'h0000CAFE, lat, st, res);
        check("cafe_lat", 32'(lat), 32'd18);
        check("cafe_status", st, 32'h1);
        check("cafe_result", res, 32'h00051966);
        @(negedge clk);
        check("dout_idle_zero", d_out, 32'd0);
        bus_read(A_DATA, rv);
        check("unmapped_read", rv, 32'd0);
        convert(2'b00, 32'h00000000, lat, st, res);
        check("zero_result", res, 32'h00000000);
        convert(2'b00, 32'h0000FFFF, lat, st, res);
        check("ffff_result", res, 32'h00065535);

        // bcd->bin directed
        convert(2'b01, 32'h00065535, lat, st, res);
        check("r65535_status", st, 32'h1);
        check("r65535_result", res, 32'h0000FFFF);
        convert(2'b01, 32'h00065536, lat, st, res);
        check("r65536_lat", 32'(lat), 32'd18);
        check("r65536_status", st, 32'h5);
        check("r65536_result", res, 32'h0);
        convert(2'b01, 32'h0001A234, lat, st, res);
        check("badbcd_lat", 32'(lat), 32'd2);
        check("badbcd_status", st, 32'h5);
        check("badbcd_result", res, 32'h0);

        // Start while busy is ignored; DATA_IN still updates
        bus_write(A_MODE, 32'd0);
        bus_write(A_DATA, 32'h00001234);
        bus_write(A_CTRL, 32'd1);
        repeat (2) @(negedge clk);
        bus_write(A_DATA, 32'h00000001);
        bus_write(A_CTRL, 32'd1);
        wait_done(lat, st);
        bus_read(A_RESULT, res);
        check("busy_start_result", res, 32'h00004660);
        bus_write(A_CTRL, 32'd1);
        wait_done(lat, st);
        bus_read(A_RESULT, res);
        check("data_updated_result", res, 32'h00000001);

        // Reset mid-conversion
        bus_write(A_MODE, 32'd2);
        bus_write(A_DATA, 32'h00000999);
        bus_write(A_CTRL, 32'd1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_dout", d_out, 32'd0);
        bus_read(A_STATUS, rv);
        check("midrst_status", rv, 32'd0);
        bus_read(A_RESULT, rv);
        check("midrst_result", rv, 32'd0);

        // Interrupt behaviour
        convert(2'b10, 32'h000000FF, lat, st, res);
        check("irq_high", {31'd0, irq}, 32'd1);
        check("irq_result", res, 32'h00000255);
        bus_write(A_CTRL, 32'd1);
        check("irq_drop_start", {31'd0, irq}, 32'd0);
        wait_done(lat, st);
        check("irq_again", {31'd0, irq}, 32'd1);
        bus_write(A_MODE, 32'd0);
        check("irq_drop_en", {31'd0, irq}, 32'd0);

        // Random conversions against the arithmetic model
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                v = (k == 0) ? 0 : $urandom_range(0, 2**WIDTH - 1);
                convert(2'b00, v, lat, st, res);
                check("rnd_fwd_lat", 32'(lat), 32'd18);
                check("rnd_fwd_status", st, 32'h1);
                check("rnd_fwd_result", res, model_to_bcd(v));
            end else begin
                b = '0;
                for (int i = 0; i < DIGITS; i++)
                    b[4*i +: 4] = 4'($urandom_range(0, 9));
                if ($urandom_range(0, 1) == 0)
                    b[4*DIGITS-1 -: 4] = 4'($urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0)
                    b[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
                m = model_from_bcd(b);
                convert(2'b01, b, lat, st, res);
                check("rnd_rev_status", st, m[32] ? 32'h5 : 32'h1);
                check("rnd_rev_result", res, m[31:0]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/peripheral_bcdconv.md
# peripheral_bcdconv

Memory-mapped, parametrised binary/BCD converter peripheral on the femtoRV data bus. Converts an unsigned WIDTH-bit binary value to DIGITS packed BCD digits (double dabble) or packed BCD back to binary (reverse double dabble), one bit per clock. Adds to the 16-bit bin2bcd peripheral: configurable widths, a direction mode, BCD validation, an overflow/error flag, busy status and an optional done interrupt.

## Interface
- WIDTH, 16: binary operand/result width, 4..28; zero-extended to 32 bits on read.
- DIGITS, 5: BCD digit count, 1..8; integration must guarantee 10^DIGITS > 2^WIDTH-1.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- d_in  in  32  write data.
- cs  in  1  chip select.
- addr  in  5  byte address within peripheral.
- rd  in  1  read strobe, qualified by cs.
- wr  in  1  write strobe, qualified by cs.
- d_out  out  32  registered read data.
- irq  out  1  done interrupt, = done & irq_en.

## Operation
- Register map, where "write" means cs&wr and "read" means cs&rd:
  - 0x04 DATA_IN (W): operand.
  - 0x08 MODE (W): bit0 dir, 0 = bin->bcd, 1 = bcd->bin; bit1 irq_en.
  - 0x0C CTRL (W): bit0 = 1 starts a conversion; 0 has no effect.
  - 0x10 STATUS (R): bit0 done, bit1 busy, bit2 err.
  - 0x14 RESULT (R).
  - Unmapped reads return 0. Unmapped writes are ignored.
- FSM states: IDLE, LOAD, SHIFT, FINISH.
  - IDLE: start -> LOAD. Snapshot DATA_IN and dir; clear done and err.
  - LOAD: initialise the shift register (BCD part 4*DIGITS bits, binary part WIDTH bits); cnt = WIDTH.
    - bin->bcd: BCD part = 0, binary part = DATA_IN[WIDTH-1:0] -> SHIFT.
    - bcd->bin: BCD part = DATA_IN[4*DIGITS-1:0], binary part = 0. If any nibble > 9: err = 1 -> FINISH. Otherwise -> SHIFT.
  - SHIFT (one iteration per cycle, cnt decrements, cnt == 1 -> FINISH):
    - bin->bcd: add 3 to each digit >= 5, then shift the whole register left by 1.
    - bcd->bin: shift right by 1 (BCD LSB enters binary MSB), then subtract 3 from each digit >= 8.
  - FINISH: latch RESULT; done = 1 -> IDLE.
    - bin->bcd: RESULT = BCD part, zero-extended.
    - bcd->bin: if the BCD part is nonzero, err = 1 (value >= 2^WIDTH). RESULT = binary part, or 0 on err.
- busy = (state != IDLE).
- done and err are sticky until the next accepted start.
- RESULT changes only in FINISH. A read during busy returns the previous result.
- Boundary rules:
  - Start while busy: ignored. Current conversion unaffected.
  - DATA_IN or MODE written while busy: registers update; the current conversion uses its snapshot.
  - Simultaneous CTRL start and other bus access in the same cycle: not possible (single bus); back-to-back start after done: accepted normally.
  - Reset mid-conversion: FSM -> IDLE; all registers, d_out and irq cleared next edge; no result produced.

## Timing
- Reset values are 0: d_out, irq, DATA_IN, MODE, RESULT, done, busy, err, FSM = IDLE.
- Start write sampled at edge E0.
  - busy is visible after E0.
  - LOAD completes at E1. SHIFT runs edges E2..E(WIDTH+1).
  - FINISH at E(WIDTH+2): done = 1, busy = 0.
  - Total latency WIDTH+2 cycles (18 for WIDTH=16).
- Invalid BCD: done = 1, err = 1 after E2.
- Read: d_out is loaded at the edge sampling cs&rd and is 0 the cycle after any non-read. One-cycle read latency.
- irq rises the same edge as done and drops on the edge accepting the next start, or when irq_en is cleared.

## Test plan
- Reset, then read STATUS and RESULT -> both 0; irq = 0; d_out = 0.
- WIDTH=16: write DATA_IN=0xCAFE, MODE=0, CTRL=1 -> busy for 18 cycles, STATUS=0x1, RESULT=0x00051966. Also 0x0000 -> 0x00000000 and 0xFFFF -> 0x00065535.
- MODE=1: DATA_IN=0x00065535 -> RESULT=0x0000FFFF, err=0. DATA_IN=0x00065536 -> err=1, RESULT=0, done after 18 cycles.
- MODE=1: DATA_IN=0x0001A234 -> STATUS=0x5 two cycles after start, RESULT=0.
- Start 0x1234 (bin->bcd), rewrite DATA_IN=0x0001 and CTRL=1 at cycle 5 -> start ignored, RESULT=0x00004660.
- Reset at cycle 8 of another conversion -> state IDLE, STATUS=0, RESULT=0.
- MODE=0x2, start 0x00FF -> irq=1 with done, RESULT=0x00000255. The next start drops irq at its edge.
